core_bus_arbiter: RTL and testbench
===================================

# core_bus_arbiter

Round-robin arbiter that shares one peripheral core's register port between several bus masters. It serialises register read and write requests into single-cycle `write_en`/`read_en` strobes on the core's `core_io` signal set. It returns read data and an acknowledge to the winning master, and forwards the core interrupt. It sits between the system bus masters and one core instance.

## Interface
- `MASTERS`, default 2: number of requesters, minimum 2.
- `REGS`, default 3: number of core registers; must match the attached core.
- `ADDR_W`, default 2: register address width; 2**ADDR_W >= REGS.

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `req` in MASTERS: per-master request, held until ack.
- `wr` in MASTERS: per-master access type, 1=write, 0=read.
- `addr` in MASTERS*ADDR_W: per-master register index; master m uses slice [m*ADDR_W +: ADDR_W].
- `wdata` in MASTERS*32: per-master write data; master m uses [m*32 +: 32].
- `ack` out MASTERS: one-cycle completion pulse to the granted master.
- `err` out 1: valid with ack; 1 = address >= REGS.
- `rdata` out 32: read data, valid with ack; 0 for writes and errors.
- `irq` out 1: core `irq_out`, passed through combinationally.
- `core_data_in` out 32: maps to core_io `data_in`.
- `core_data_out` in REGS x 32: maps to core_io `data_out`.
- `core_write_en` out REGS: maps to core_io `write_en`.
- `core_read_en` out REGS: maps to core_io `read_en`.
- `core_irq` in 1: maps to core_io `irq_out`.
- The core's clk/reset are driven from `clk`/`reset` unchanged.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any `req` is high, pick a winner g by round-robin, then go to ACCESS.
  - Latch g, `wr[g]`, `addr[g]` and `wdata[g]` into registers.
- ACCESS, lasting exactly one cycle:
  - If the latched addr < REGS, assert `core_write_en[addr]` (write) or `core_read_en[addr]` (read), one-hot.
  - `core_data_in` = latched wdata during writes; otherwise `core_data_in` = 0.
  - On a read, capture `core_data_out[addr]` into the rdata register at the end of the cycle.
  - If addr >= REGS: no strobe, and set the err register.
  - Go to RESP.
- RESP, lasting exactly one cycle:
  - Assert `ack[g]`, drive `err`/`rdata`.
  - Update the round-robin pointer to g, then go to IDLE.
- Round-robin rule:
  - Search starts at pointer+1 (mod MASTERS).
  - Reset pointer = MASTERS-1, so master 0 has top priority first.
- Requester rule:
  - Hold `req`, `wr`, `addr` and `wdata` stable from assertion until `ack`.
  - Deassert `req` on the edge ending the ack cycle unless issuing a new transaction.
  - Input changes are ignored outside IDLE, since all operands are latched.
- Outside ACCESS all strobes are 0; outside RESP, `ack` = 0, `err` = 0, `rdata` = 0.
- A `req` dropped while the FSM is in ACCESS/RESP does not cancel the transaction; ack is still issued.
- Reset values: state IDLE, ack 0, err 0, rdata 0, `core_write_en` 0, `core_read_en` 0, `core_data_in` 0, pointer MASTERS-1.
  - `irq` follows `core_irq`.
- Reset mid-transaction: everything returns to reset values immediately (asynchronous); no ack is ever issued for the aborted access.
- All outputs except `irq` are registered.

## Timing
- Request seen in IDLE at cycle T:
  - Strobe in cycle T+1.
  - ack/rdata/err in cycle T+2.
  - IDLE again in T+3.
- Latency is 2 cycles from request to ack. Throughput is one transaction per 3 cycles.
- Read data reflects the core register value during the strobe cycle T+1.
- A write takes effect in the core at the edge ending T+1 and is visible to a read strobed at T+4 or later.
- Two masters requesting at T, pointer=MASTERS-1:
  - Master 0 acks at T+2.
  - Master 1 is granted at T+3 and acks at T+5.
- `irq` has zero latency relative to `core_irq`.

## Test plan
- Master 0 writes addr 1, wdata 0x0000_0003, at T → `core_write_en` = 3'b010 and `core_data_in` = 0x3 for exactly cycle T+1; `ack[0]` at T+2, err=0, rdata=0; core config reads back 0x3.
- Core counter preloaded to 0x0000_0010 with counting disabled; master 1 reads addr 0 → `core_read_en` = 3'b001 at T+1; `ack[1]` at T+2 with rdata = 0x0000_0010.
- Both masters request at T right after reset → acks: `ack[0]` at T+2, `ack[1]` at T+5; never two acks in one cycle.
- Master 0 requests continuously while master 1 requests → grants alternate 0,1,0,1; neither master waits more than one transaction.
- Master 0 reads addr 3 with REGS=3 → no strobes at T+1; `ack[0]` at T+2 with err=1, rdata=0.
- Reset asserted during ACCESS → strobes drop in the same cycle, no ack follows. After release, a simultaneous request from both masters grants master 0 first.

Source files
------------

// File: rtl/core_bus_arbiter.sv
// Round-robin arbiter sharing one core's register port between several bus masters.
// Each access is IDLE -> ACCESS (one strobe cycle) -> RESP (ack cycle); irq passes straight through.
module core_bus_arbiter #(
    parameter int MASTERS = 2,
    parameter int REGS    = 3,
    parameter int ADDR_W  = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [MASTERS-1:0]        req,
    input  logic [MASTERS-1:0]        wr,
    input  logic [MASTERS*ADDR_W-1:0] addr,
    input  logic [MASTERS*32-1:0]     wdata,
    output logic [MASTERS-1:0]        ack,
    output logic                      err,
    output logic [31:0]               rdata,
    output logic                      irq,
    output logic [31:0]               core_data_in,
    input  logic [REGS*32-1:0]        core_data_out,
    output logic [REGS-1:0]           core_write_en,
    output logic [REGS-1:0]           core_read_en,
    input  logic                      core_irq
);
    localparam int GW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
    localparam logic [ADDR_W:0] REGS_LIM = REGS[ADDR_W:0];

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t              r_state, w_state_next;
    logic [GW-1:0]       r_gnt, w_gnt_next;
    logic [GW-1:0]       r_ptr, w_ptr_next;
    logic [GW-1:0]       w_winner;
    logic                w_found;
    logic                r_wr, w_wr_next;
    logic [ADDR_W-1:0]   r_addr, w_addr_next;
    logic [31:0]         r_wdata, w_wdata_next;
    logic [MASTERS-1:0]  w_ack_next;
    logic                w_err_next;
    logic [31:0]         w_rdata_next;
    logic [31:0]         w_din_next;
    logic [REGS-1:0]     w_we_next, w_re_next;
    logic [31:0]         w_core_word;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic                w_lat_valid;

    logic [ADDR_W-1:0]   w_addr_m  [MASTERS];
    logic [31:0]         w_wdata_m [MASTERS];
    logic [31:0]         w_core_m  [REGS];

    generate
        for (genvar gi = 0; gi < MASTERS; gi++) begin : g_master
            assign w_addr_m[gi]  = addr[gi*ADDR_W +: ADDR_W];
            assign w_wdata_m[gi] = wdata[gi*32 +: 32];
        end
        for (genvar gi = 0; gi < REGS; gi++) begin : g_reg
            assign w_core_m[gi] = core_data_out[gi*32 +: 32];
        end
    endgenerate

    assign irq         = core_irq;
    assign w_sel_addr  = w_addr_m[w_winner];
    assign w_lat_valid = {1'b0, r_addr} < REGS_LIM;

    // First pass takes requesters above the pointer, second wraps around to the rest.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_ptr;
        for (int j = 0; j < MASTERS; j++) begin
            if (!w_found && req[j] && (j > int'(r_ptr))) begin
                w_found  = 1'b1;
                w_winner = GW'(j);
            end
        end
        for (int j = 0; j < MASTERS; j++) begin
            if (!w_found && req[j]) begin
                w_found  = 1'b1;
                w_winner = GW'(j);
            end
        end
    end

    always_comb begin
        w_core_word = '0;
        for (int k = 0; k < REGS; k++) begin
            if (r_addr == ADDR_W'(k)) w_core_word = w_core_m[k];
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_gnt_next   = r_gnt;
        w_ptr_next   = r_ptr;
        w_wr_next    = r_wr;
        w_addr_next  = r_addr;
        w_wdata_next = r_wdata;
        w_ack_next   = '0;
        w_err_next   = 1'b0;
        w_rdata_next = '0;
        w_din_next   = '0;
        w_we_next    = '0;
        w_re_next    = '0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_next = S_ACCESS;
                    w_gnt_next   = w_winner;
                    w_wr_next    = wr[w_winner];
                    w_addr_next  = w_sel_addr;
                    w_wdata_next = w_wdata_m[w_winner];
                    // Strobes are registered, so they are decided here for the ACCESS cycle.
                    for (int k = 0; k < REGS; k++) begin
                        if (w_sel_addr == ADDR_W'(k)) begin
                            w_we_next[k] = wr[w_winner];
                            w_re_next[k] = !wr[w_winner];
                        end
                    end
                    if (wr[w_winner]) w_din_next = w_wdata_m[w_winner];
                end
            end
            S_ACCESS: begin
                w_state_next       = S_RESP;
                w_ack_next[r_gnt]  = 1'b1;
                w_err_next         = !w_lat_valid;
                w_rdata_next       = (!r_wr && w_lat_valid) ? w_core_word : 32'h0;
            end
            S_RESP: begin
                w_state_next = S_IDLE;
                w_ptr_next   = r_gnt;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_gnt         <= '0;
            r_ptr         <= GW'(MASTERS - 1);
            r_wr          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            ack           <= '0;
            err           <= 1'b0;
            rdata         <= '0;
            core_data_in  <= '0;
            core_write_en <= '0;
            core_read_en  <= '0;
        end else begin
            r_state       <= w_state_next;
            r_gnt         <= w_gnt_next;
            r_ptr         <= w_ptr_next;
            r_wr          <= w_wr_next;
            r_addr        <= w_addr_next;
            r_wdata       <= w_wdata_next;
            ack           <= w_ack_next;
            err           <= w_err_next;
            rdata         <= w_rdata_next;
            core_data_in  <= w_din_next;
            core_write_en <= w_we_next;
            core_read_en  <= w_re_next;
        end
    end
endmodule

// File: tb/tb_core_bus_arbiter.sv
// Self-checking bench for core_bus_arbiter: a register-file core model plus a
// transaction-level reference that predicts strobe/ack cycles from request times.
module tb_core_bus_arbiter;
    localparam int M  = 2;
    localparam int R  = 3;
    localparam int AW = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [M-1:0]      req, wr;
    logic [M*AW-1:0]   addr;
    logic [M*32-1:0]   wdata;
    logic [M-1:0]      ack;
    logic              err;
    logic [31:0]       rdata;
    logic              irq;
    logic [31:0]       core_data_in;
    logic [R*32-1:0]   core_data_out;
    logic [R-1:0]      core_write_en, core_read_en;
    logic              core_irq;

    core_bus_arbiter #(.MASTERS(M), .REGS(R), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
        .ack(ack), .err(err), .rdata(rdata), .irq(irq), .core_data_in(core_data_in),
        .core_data_out(core_data_out), .core_write_en(core_write_en),
        .core_read_en(core_read_en), .core_irq(core_irq)
    );

    always #5 clk = ~clk;

    // Minimal core: plain registers, preloadable from the bench.
    logic [31:0] core_regs [R];
    logic        pl_en  = 1'b0;
    logic [1:0]  pl_idx = 2'd0;
    logic [31:0] pl_val = 32'h0;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < R; k++) core_regs[k] <= '0;
        end else begin
            if (pl_en) core_regs[pl_idx] <= pl_val;
            for (int k = 0; k < R; k++) if (core_write_en[k]) core_regs[k] <= core_data_in;
        end
    end
    generate
        for (genvar gi = 0; gi < R; gi++) begin : g_core
            assign core_data_out[gi*32 +: 32] = core_regs[gi];
        end
    endgenerate

    int n_cmp = 0, n_fail = 0;
    int cyc = 0;
    int t_acc, t_resp, t_free, ptr, g;
    logic p_wr; int p_addr; logic [31:0] p_wdata, exp_rdata;
    logic [31:0] ref_mem [R];
    logic pend [M]; logic pw [M]; int pa [M]; logic [31:0] pd [M];
    logic sticky [M];
    logic rand_mode, rst_req;
    int obs_g_q[$]; int obs_c_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    function automatic logic any_pend();
        for (int m = 0; m < M; m++) if (pend[m]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        ptr = M - 1; t_acc = -1; t_resp = -1; t_free = 0; exp_rdata = 0;
        for (int m = 0; m < M; m++) pend[m] = 1'b0;
        for (int k = 0; k < R; k++) ref_mem[k] = 32'h0;
    endtask

    task automatic new_txn(input int m, input logic w, input int a, input logic [31:0] d);
        pend[m] = 1'b1; pw[m] = w; pa[m] = a; pd[m] = d;
    endtask

    task automatic new_rand(input int m);
        new_txn(m, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), $urandom());
    endtask

    task automatic drive();
        for (int m = 0; m < M; m++) begin
            req[m]              = pend[m];
            wr[m]               = pw[m];
            addr[m*AW +: AW]    = AW'(pa[m]);
            wdata[m*32 +: 32]   = pd[m];
        end
    endtask

    // One clock cycle: check outputs, advance the model, drive the next inputs.
    task automatic step();
        logic [R-1:0] e_we, e_re;
        logic [M-1:0] e_ack;
        logic         e_err, rose;
        logic [31:0]  e_din, e_rd;
        @(negedge clk);
        e_we = '0; e_re = '0; e_ack = '0; e_err = 1'b0; e_din = '0; e_rd = '0;
        if (!reset && cyc == t_acc) begin
            if (p_addr < R) begin
                if (p_wr) e_we = R'(1 << p_addr);
                else      e_re = R'(1 << p_addr);
            end
            e_din     = p_wr ? p_wdata : 32'h0;
            exp_rdata = (!p_wr && p_addr < R) ? ref_mem[p_addr] : 32'h0;
        end
        if (!reset && cyc == t_resp) begin
            e_ack = M'(1 << g);
            e_err = (p_addr >= R);
            e_rd  = exp_rdata;
        end
        check("write_en", 32'(core_write_en), 32'(e_we));
        check("read_en",  32'(core_read_en),  32'(e_re));
        check("data_in",  core_data_in,       e_din);
        check("ack",      32'(ack),           32'(e_ack));
        check("err",      32'(err),           32'(e_err));
        check("rdata",    rdata,              e_rd);
        for (int m = 0; m < M; m++) if (ack[m]) begin
            obs_g_q.push_back(m);
            obs_c_q.push_back(cyc);
        end
        if (!reset && cyc == t_acc && p_wr && p_addr < R) ref_mem[p_addr] = p_wdata;
        if (!reset && cyc == t_resp) begin
            $display("cyc %0d: master %0d %s addr %0d wdata %h -> err %0b rdata %h",
                     cyc, g, p_wr ? "write" : "read ", p_addr, p_wdata, e_err, e_rd);
            ptr = g;
            pend[g] = 1'b0;
            if (sticky[g]) new_rand(g);
        end
        rose = rst_req && !reset;
        if (rst_req != reset) begin
            reset = rst_req;
            if (reset) model_reset();
        end
        if (rand_mode) for (int m = 0; m < M; m++) if (!pend[m] && $urandom_range(0, 3) == 0) new_rand(m);
        drive();
        core_irq = 1'($urandom_range(0, 1));
        #1;
        check("irq", 32'(irq), 32'(core_irq));
        if (rose) begin
            check("rst_write_en", 32'(core_write_en), 32'h0);
            check("rst_read_en",  32'(core_read_en),  32'h0);
            check("rst_ack",      32'(ack),           32'h0);
        end
        if (!reset && cyc >= t_free && any_pend()) begin
            for (int k = 1; k <= M; k++) begin
                int m;
                m = (ptr + k) % M;
                if (pend[m]) begin g = m; break; end
            end
            p_wr = pw[g]; p_addr = pa[g]; p_wdata = pd[g]; exp_rdata = 32'h0;
            t_acc = cyc + 1; t_resp = cyc + 2; t_free = cyc + 3;
        end
        cyc++;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((any_pend() || cyc < t_free) && n < budget) begin
            step();
            n++;
        end
        check("drain_budget", 32'(n < budget), 32'h1);
    endtask

    initial begin
        int t0, n0, n;
        reset = 1'b1; rst_req = 1'b1; rand_mode = 1'b0;
        req = '0; wr = '0; addr = '0; wdata = '0; core_irq = 1'b0;
        for (int m = 0; m < M; m++) begin
            sticky[m] = 1'b0; pw[m] = 1'b0; pa[m] = 0; pd[m] = '0;
        end
        model_reset();
        repeat (3) step();
        rst_req = 1'b0;
        step();

        // Write 3 to register 1 from master 0.
        new_txn(0, 1'b1, 1, 32'h3);
        t0 = cyc;
        drain(20);
        check("wr_ack_latency", 32'(obs_c_q[$] - t0), 32'd2);
        check("wr_ack_master",  32'(obs_g_q[$]),      32'd0);
        check("cfg_readback",   core_regs[1],         32'h3);

        // Preloaded register 0 read by master 1.
        pl_idx = 2'd0; pl_val = 32'h10; pl_en = 1'b1; ref_mem[0] = 32'h10;
        step();
        pl_en = 1'b0;
        new_txn(1, 1'b0, 0, 32'h0);
        t0 = cyc;
        drain(20);
        check("rd_ack_latency", 32'(obs_c_q[$] - t0), 32'd2);
        check("rd_ack_master",  32'(obs_g_q[$]),      32'd1);

        // Both masters right after reset: master 0 first, master 1 three cycles later.
        rst_req = 1'b1; step(); step();
        rst_req = 1'b0;
        new_txn(0, 1'b0, 1, 32'h0);
        new_txn(1, 1'b1, 2, 32'hA5A5_0001);
        n0 = obs_g_q.size();
        t0 = cyc;
        drain(30);
        check("both_count",  32'(obs_g_q.size() - n0), 32'd2);
        check("both_first",  32'(obs_g_q[n0]),         32'd0);
        check("both_t0",     32'(obs_c_q[n0] - t0),    32'd2);
        check("both_second", 32'(obs_g_q[n0+1]),       32'd1);
        check("both_t1",     32'(obs_c_q[n0+1] - t0),  32'd5);

        // Both masters requesting back to back: grants must alternate 0,1,0,1,...
        sticky[0] = 1'b1; sticky[1] = 1'b1;
        new_rand(0); new_rand(1);
        n0 = obs_g_q.size();
        n = 0;
        while (obs_g_q.size() < n0 + 6 && n < 60) begin step(); n++; end
        check("alt_budget", 32'(n < 60), 32'h1);
        sticky[0] = 1'b0; sticky[1] = 1'b0;
        drain(30);
        for (int i = 0; i < 6 && n0 + i < obs_g_q.size(); i++)
            check("alternate", 32'(obs_g_q[n0+i]), 32'(i % 2));

        // Out-of-range addresses: error response, no strobe.
        new_txn(0, 1'b0, 3, 32'h0);
        t0 = cyc;
        drain(20);
        check("err_ack_latency", 32'(obs_c_q[$] - t0), 32'd2);
        new_txn(1, 1'b1, 3, 32'hDEAD_BEEF);
        drain(20);

        // Reset during ACCESS aborts the access; afterwards master 0 wins first.
        new_txn(0, 1'b1, 2, 32'h55);
        n = 0;
        step();
        while (cyc != t_acc && n < 10) begin step(); n++; end
        check("abort_reach", 32'(n < 10), 32'h1);
        n0 = obs_g_q.size();
        rst_req = 1'b1;
        step(); step(); step();
        check("abort_no_ack", 32'(obs_g_q.size() - n0), 32'd0);
        rst_req = 1'b0;
        new_txn(0, 1'b0, 2, 32'h0);
        new_txn(1, 1'b0, 1, 32'h0);
        t0 = cyc;
        drain(30);
        check("post_rst_first", 32'(obs_g_q[n0]),      32'd0);
        check("post_rst_t0",    32'(obs_c_q[n0] - t0), 32'd2);

        // Random traffic against the reference.
        rand_mode = 1'b1;
        repeat (400) step();
        rand_mode = 1'b0;
        drain(30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
